// File: rtl/lfsr_pkg.sv
// Shared constants for the 32-bit LFSR generator and its stream checker.
// Tap positions index the history register, where bit 0 is the newest bit.
package lfsr_pkg;

    localparam int LFSR_LEN = 32;
    localparam int TAP0     = 0;
    localparam int TAP1     = 22;
    localparam int TAP2     = 30;
    localparam int TAP3     = 31;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    function automatic logic lfsr_predict(input logic [LFSR_LEN-1:0] h);
        return h[TAP0] ^ h[TAP1] ^ h[TAP2] ^ h[TAP3];
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the LFSR bit stream: fills, verifies, then flywheels.
// Optional LFSR_CHK_STUCK_EN: refuse to lock on the all-zero lock-up stream and flag it.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int WINDOW    = 64,
    parameter int LOSS_ERRS = 4,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_data,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_stuck
);

    localparam int FILL_W  = $clog2(LFSR_LEN);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int ERR_W   = $clog2(LOSS_ERRS + 1);

    chk_state_e           state_q, state_d;
    logic [LFSR_LEN-1:0]  h_q, h_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]     win_bit_q, win_bit_d;
    logic [ERR_W-1:0]     win_err_q, win_err_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 err_q, err_d;
    logic                 locked_q, locked_d;
    logic                 stuck_q, stuck_d;

    logic                 pred;
    logic                 mism;
    logic                 hold_match;
    logic [ERR_W-1:0]     win_err_nx;

    assign pred = lfsr_predict(h_q);
    assign mism = i_data ^ pred;

`ifdef LFSR_CHK_STUCK_EN
    logic h_zero;
    assign h_zero     = (h_q == '0);
    // An all-zero history trivially satisfies the recurrence; never count it toward lock.
    assign hold_match = h_zero;
    assign stuck_d    = (state_q != ST_SEARCH) && h_zero;
`else
    assign hold_match = 1'b0;
    assign stuck_d    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        fill_d     = fill_q;
        match_d    = match_q;
        win_bit_d  = win_bit_q;
        win_err_d  = win_err_q;
        err_cnt_d  = err_cnt_q;
        err_d      = 1'b0;
        win_err_nx = win_err_q;

        if (i_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    h_d = {h_q[LFSR_LEN-2:0], i_data};
                    if (fill_q == FILL_W'(LFSR_LEN - 1)) begin
                        state_d = ST_VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end

                ST_VERIFY: begin
                    h_d = {h_q[LFSR_LEN-2:0], i_data};
                    if (mism) begin
                        match_d = '0;
                    end else if (!hold_match) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_d   = ST_LOCKED;
                            match_d   = '0;
                            win_bit_d = '0;
                            win_err_d = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end
                end

                ST_LOCKED: begin
                    err_d = mism;
                    if (mism && (err_cnt_q != {CNT_W{1'b1}}))
                        err_cnt_d = err_cnt_q + 1'b1;

                    // The wrap bit opens the new window, so its error lands there.
                    if (win_bit_q == WIN_W'(WINDOW - 1)) begin
                        win_bit_d  = '0;
                        win_err_nx = ERR_W'(mism);
                    end else begin
                        win_bit_d  = win_bit_q + 1'b1;
                        win_err_nx = win_err_q + ERR_W'(mism);
                    end

                    if (win_err_nx == ERR_W'(LOSS_ERRS)) begin
                        state_d   = ST_SEARCH;
                        fill_d    = '0;
                        win_err_d = '0;
                    end else begin
                        // Flywheel on the prediction so received errors never enter h.
                        h_d       = {h_q[LFSR_LEN-2:0], pred};
                        win_err_d = win_err_nx;
                    end
                end

                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_SEARCH;
            h_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            win_bit_q <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_q       <= h_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            win_bit_q <= win_bit_d;
            win_err_q <= win_err_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            locked_q  <= locked_d;
            stuck_q   <= stuck_d;
        end
    end

    assign o_locked  = locked_q;
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;
    assign o_stuck   = stuck_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

- Serial receiver and checker for the 32-bit pseudo-random bit stream produced by the design's LFSR generator (recurrence s[n] = s[n-1] ^ s[n-23] ^ s[n-31] ^ s[n-32]).
- Self-synchronises onto the incoming stream, declares lock, then flywheels its own prediction to flag and count bit errors.
- Sits on the generator's output in test/bring-up builds, verifying the random seeding path for the life grid without a shared seed.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive correct predictions required to declare lock.
- WINDOW, 64: length in valid bits of the error-observation window while locked.
- LOSS_ERRS, 4: errors within one window that drop lock.
- CNT_W, 16: width of the saturating error counter.

Ports:
- i_clk  in  1  single clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  qualifies i_data; tie high when fed directly from the generator.
- i_data  in  1  received stream bit.
- o_locked  out  1  checker is in LOCKED.
- o_err  out  1  one-cycle pulse on a mismatching bit while locked.
- o_err_cnt  out  CNT_W  total errors since reset; saturates at all-ones.
- o_stuck  out  1  history register is all-zero (generator lock-up state).

## Operation
- History h[31:0] holds the last 32 bits, where h[0] is the newest. Prediction p = h[0]^h[22]^h[30]^h[31].
- Nothing changes on cycles with i_valid=0: no shift, no counter change, no o_err.
- States and transitions:
  - SEARCH (reset state): shift i_data into h; count fill bits; after the 32nd valid bit, go to VERIFY with match counter 0.
  - VERIFY: compare i_data with p, then shift in i_data. A match increments the match counter; a mismatch clears it and stays in VERIFY. When the match counter reaches LOCK_CNT, go to LOCKED and clear the window counters.
  - LOCKED: shift in p, not i_data (flywheel), so a received error never propagates into h. On a mismatch, pulse o_err, increment o_err_cnt (saturating), and increment the window error count. When the window error count reaches LOSS_ERRS, go to SEARCH, clear the fill count, and leave h unchanged.
- Window rules: the window bit counter wraps after WINDOW valid bits and clears the window error count at the wrap. A mismatch on the wrap bit counts in the new window.
- o_err_cnt is never cleared except by reset; it counts only in LOCKED.

## Timing
- All outputs are registered. Reset values: o_locked=0, o_err=0, o_err_cnt=0, o_stuck=0. Reset also sets state=SEARCH, h=0, and all counters to 0.
- Reset asynchronously clears all outputs, including mid-LOCKED or during an o_err pulse.
- Error latency: o_err goes high the cycle after the edge that samples the bad bit, for exactly one cycle.
- Lock latency: from a clean start, o_locked rises the cycle after the edge that accepts valid bit 32+LOCK_CNT (48 by default).
- Loss of lock: o_locked falls in the same cycle that o_err shows the LOSS_ERRS-th error.
- o_stuck reflects h==0 with one-cycle latency, in VERIFY and LOCKED only.

## Configuration
- LFSR_CHK_STUCK_EN defined:
  - VERIFY does not advance the match counter while h==0.
  - o_stuck asserts when h==0.
  - An all-zero stream therefore never locks.
- LFSR_CHK_STUCK_EN undefined:
  - o_stuck is tied 0.
  - The all-zero stream satisfies the recurrence and locks normally.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_LEN=32.
  - Tap indices 0, 22, 30, 31.
  - Checker state encoding (SEARCH, VERIFY, LOCKED).
- The generator uses the same tap constants.
- No sub-module: prediction is a single XOR, and the counters stay inline.

## Test plan
- Reset, i_valid=0 for 100 cycles -> all outputs 0, o_err never pulses.
- Clean stream from a model generator seeded 32'h0000_0001, i_valid=1 -> o_locked rises after 48 valid bits; o_err_cnt=0 after 1000 bits.
- Locked, invert valid bit 200 only -> single o_err pulse, o_err_cnt=1, o_locked stays 1, and no further errors over 500 bits.
- Locked, invert 4 bits inside one 64-bit window -> o_locked falls with the 4th o_err, o_err_cnt=4, and re-lock occurs 48 valid bits later.
- All-zero stream (generator released from reset unseeded):
  - With LFSR_CHK_STUCK_EN: o_stuck=1 after 33 bits and o_locked=0 indefinitely.
  - Without LFSR_CHK_STUCK_EN: o_locked=1 after 48 bits.
- i_valid toggling every other cycle, then i_rst_n pulsed low mid-LOCKED -> lock after 48 valid bits (96 cycles), and all outputs 0 immediately on reset assertion.
